// File: rtl/bcd_conv_pkg.sv
// Shared types, sizes and the add-3 helper for the shared binary-to-BCD converter.
package bcd_conv_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int DATA_W = 16;
   localparam int DIGITS = 4;
   localparam int ITER   = 16;
   localparam int ACC_W  = 4 * (DIGITS + 1);

   localparam logic [DATA_W-1:0] MAX_DEC = 16'd9999;
   localparam logic [DATA_W-1:0] SAT_BCD = 16'h9999;

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
      logic [ACC_W-1:0] r;
      r = a;
      for (int d = 0; d < DIGITS + 1; d++) begin
         if (a[4*d +: 4] >= 4'd5) r[4*d +: 4] = a[4*d +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_dd_core.sv
// Serial double-dabble datapath: load a 16-bit value, then 16 add-3/shift steps.
module bcd_dd_core
   import bcd_conv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic [ACC_W-1:0]  acc,
   output logic              done
);

   localparam int CNT_W = $clog2(ITER + 1);

   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;
   logic [ACC_W-1:0]  adj;

   assign adj  = add3(acc);
   assign done = (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else if (load) begin
         shreg <= data;
         acc   <= '0;
         cnt   <= CNT_W'(ITER);
      end else if (cnt != '0) begin
         acc   <= ACC_W'({adj, shreg[DATA_W-1]});
         shreg <= shreg << 1;
         cnt   <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one serial BCD converter among NREQ requesters.
// Define BCD_CONV_ARB_SAT_EN to saturate out-of-range results to 0x9999.
//
// state | meaning
// IDLE  | offering a grant to the next round-robin requester
// SHIFT | conversion running; core done flags the end of the 16 steps
// DONE  | result held on out_* until out_ready
module bcd_conv_arbiter
   import bcd_conv_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [DATA_W*NREQ-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_bcd,
   output logic [ID_W-1:0]        out_id,
   output logic                   out_ovf,
   output logic                   busy
);

   state_t            state;
   logic [ID_W-1:0]   last;
   logic [ID_W-1:0]   win;
   logic [ID_W-1:0]   idx;
   logic [NREQ-1:0]   gnt;
   logic              any;
   logic              load;
   logic [ACC_W-1:0]  acc;
   logic              done;
   logic              res_ovf;
   logic [DATA_W-1:0] res_bcd;

   // Search upward from last+1 so the most recent winner has lowest priority.
   always_comb begin
      gnt = '0;
      win = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = ID_W'((int'(last) + k) % NREQ);
         if (!any && req_valid[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            win      = idx;
         end
      end
   end

   assign req_ready = (state == IDLE) ? gnt : '0;
   assign load      = (state == IDLE) && any;
   assign busy      = (state != IDLE);
   assign res_ovf   = (acc[ACC_W-1:DATA_W] != '0);

`ifdef BCD_CONV_ARB_SAT_EN
   assign res_bcd = res_ovf ? SAT_BCD : acc[DATA_W-1:0];
`else
   assign res_bcd = acc[DATA_W-1:0];
`endif

   bcd_dd_core u_core (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .data (req_data[DATA_W*int'(win) +: DATA_W]),
      .acc  (acc),
      .done (done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= ID_W'(NREQ - 1);
         out_valid <= 1'b0;
         out_bcd   <= '0;
         out_id    <= '0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  last   <= win;
                  out_id <= win;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (done) begin
                  out_valid <= 1'b1;
                  out_bcd   <= res_bcd;
                  out_ovf   <= res_ovf;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with hand-computed BCD results.
module tb_bcd_conv_arbiter;

   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [16*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_bcd;
   logic [1:0]        out_id;
   logic              out_ovf;
   logic              busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_conv_arbiter #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .out_id    (out_id),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag, input int id);
      int n;
      n = 0;
      while (!req_ready[id] && n < 60) begin
         tick();
         n++;
      end
      chk({tag, "_grant"}, 32'(req_ready), 32'(1 << id));
   endtask

   task automatic wait_out(input string tag, output int n);
      n = 0;
      while (!out_valid && n < 60) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
   endtask

   task automatic run_one(input string tag, input int id, input logic [15:0] val,
                          input logic [15:0] eb, input logic eo);
      int n;
      req_data[16*id +: 16] = val;
      req_valid[id] = 1'b1;
      #1;
      wait_ready(tag, id);
      tick();
      req_valid[id] = 1'b0;
      wait_out(tag, n);
      chk({tag, "_lat"}, 32'(n), 32'd17);
      chk({tag, "_bcd"}, {16'b0, out_bcd}, {16'b0, eb});
      chk({tag, "_id"}, {30'b0, out_id}, 32'(id));
      chk({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, eo});
      tick();
      chk({tag, "_release"}, {30'b0, out_valid, busy}, 32'd0);
   endtask

   initial begin
      int n;
      logic [1:0] exp_ids [4];
      exp_ids = '{2'd0, 2'd1, 2'd0, 2'd1};

      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_bcd",   {16'b0, out_bcd}, 32'd0);
      chk("rst_id",    {30'b0, out_id}, 32'd0);
      chk("rst_ovf",   {31'b0, out_ovf}, 32'd0);
      chk("rst_busy",  {31'b0, busy}, 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);

      run_one("r0_1234", 0, 16'd1234, 16'h1234, 1'b0);
      run_one("r2_0",    2, 16'd0,    16'h0000, 1'b0);
      run_one("r2_9999", 2, 16'd9999, 16'h9999, 1'b0);
`ifdef BCD_CONV_ARB_SAT_EN
      run_one("r1_65535", 1, 16'd65535, 16'h9999, 1'b1);
      run_one("r3_10000", 3, 16'd10000, 16'h9999, 1'b1);
`else
      run_one("r1_65535", 1, 16'd65535, 16'h5535, 1'b1);
      run_one("r3_10000", 3, 16'd10000, 16'h0000, 1'b1);
`endif

      // two requesters held from reset alternate 0,1,0,1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_data[15:0]  = 16'd4321;
      req_data[31:16] = 16'd808;
      req_valid       = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         wait_out("rr", n);
         chk("rr_id", {30'b0, out_id}, {30'b0, exp_ids[k]});
         chk("rr_bcd", {16'b0, out_bcd}, (exp_ids[k] == 2'd0) ? 32'h4321 : 32'h0808);
         tick();
      end
      req_valid = '0;
      tick();

      // consumer stall with req3 pending
      out_ready       = 1'b0;
      req_data[15:0]  = 16'd77;
      req_valid[0]    = 1'b1;
      #1;
      wait_ready("stall", 0);
      tick();
      req_valid[0]     = 1'b0;
      req_data[63:48]  = 16'd500;
      req_valid[3]     = 1'b1;
      wait_out("stall", n);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_bcd",   {16'b0, out_bcd}, 32'h0077);
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_ready", 32'(req_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      chk("stall_rel_valid", {31'b0, out_valid}, 32'd0);
      chk("stall_rel_ready", 32'(req_ready), 32'b1000);
      tick();
      chk("stall_g3_busy", {31'b0, busy}, 32'd1);
      chk("stall_g3_id",   {30'b0, out_id}, 32'd3);
      req_valid[3] = 1'b0;
      wait_out("stall_r3", n);
      chk("stall_r3_bcd", {16'b0, out_bcd}, 32'h0500);
      tick();

      // reset on the 8th SHIFT cycle
      run_one("r2_5", 2, 16'd5, 16'h0005, 1'b0);
      req_data[15:0] = 16'd9999;
      req_valid[0]   = 1'b1;
      #1;
      wait_ready("mid", 0);
      tick();
      req_valid[0] = 1'b0;
      repeat (7) tick();
      chk("mid_busy_pre", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_busy",  {31'b0, busy}, 32'd0);
      chk("mid_bcd",   {16'b0, out_bcd}, 32'd0);
      chk("mid_id",    {30'b0, out_id}, 32'd0);
      chk("mid_ovf",   {31'b0, out_ovf}, 32'd0);
      req_data[15:0]  = 16'd42;
      req_data[63:48] = 16'd7;
      req_valid       = 4'b1001;
      #1;
      chk("mid_prio", 32'(req_ready), 32'b0001);
      req_valid = '0;
      run_one("mid_42", 0, 16'd42, 16'h0042, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
